mips_instr_encoder: RTL

//  Packs decoded MIPS fields (format, opcode, rs/rt/rd, shamt, funct, imm, jaddr) into 32-bit instruction words,
//  the inverse of the core's field decode. Tags each word with a sequential instruction-memory word address.

---
 rtl/mips_instr_encoder.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder: packs decoded MIPS field bundles (R/I/J) into 32-bit words tagged with a sequential word address.
// Latency: a word appears on out_* one cycle after it is accepted (output register plus one skid entry).
// Backpressure: in_ready is registered and drops once the skid entry is occupied, so at most 2 words are ever held.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start                     begin a program (honoured in IDLE or DONE only)
//   in_valid/in_ready         input handshake for one field bundle
//   in_fmt..in_jaddr,in_last  decoded fields; in_last marks the program's final bundle
//   out_valid/out_ready       output handshake toward the instruction-memory write port
//   out_instr/out_addr/out_last  encoded word, its word address, final-word flag
//   err/err_code              sticky illegal-bundle flag and the code of the first error
//   done                      program fully drained; held until the next start
module mips_instr_encoder #(
  parameter int          ADDR_WIDTH = 10,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_fmt,
  input  logic [5:0]            in_opcode,
  input  logic [4:0]            in_rs,
  input  logic [4:0]            in_rt,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_shamt,
  input  logic [5:0]            in_funct,
  input  logic [15:0]           in_imm,
  input  logic [25:0]           in_jaddr,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instr,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_last,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic                  done
);

  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;

  localparam logic [1:0] ERR_FMT  = 2'd1;
  localparam logic [1:0] ERR_ROPC = 2'd2;
  localparam logic [1:0] ERR_JOPC = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Output register and skid entry.
  logic                  out_vld_q, out_vld_d;
  logic [31:0]           out_instr_q, out_instr_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic                  out_last_q, out_last_d;
  logic                  skid_vld_q, skid_vld_d;
  logic [31:0]           skid_instr_q, skid_instr_d;
  logic [ADDR_WIDTH-1:0] skid_addr_q, skid_addr_d;
  logic                  skid_last_q, skid_last_d;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  last_acc_q, last_acc_d;   // in_last already accepted this program
  logic                  in_ready_q, in_ready_d;
  logic                  err_q, err_d;
  logic [1:0]            err_code_q, err_code_d;

  logic        accept;
  logic        out_fire;
  logic        start_ok;
  logic [31:0] enc_word;
  logic        enc_illegal;
  logic [1:0]  enc_code;

  assign accept   = in_valid & in_ready_q;
  assign out_fire = out_vld_q & out_ready;
  assign start_ok = start & (state_q != S_RUN);

  // Field packing; illegal bundles become an all-zero NOP.
  always_comb begin
    enc_word    = 32'h0000_0000;
    enc_illegal = 1'b0;
    enc_code    = 2'd0;
    case (in_fmt)
      2'd0: begin
        if (in_opcode != 6'd0) begin
          enc_illegal = 1'b1;
          enc_code    = ERR_ROPC;
        end else begin
          enc_word = {6'd0, in_rs, in_rt, in_rd, in_shamt, in_funct};
        end
      end
      2'd1: enc_word = {in_opcode, in_rs, in_rt, in_imm};
      2'd2: begin
        if ((in_opcode == OP_J) || (in_opcode == OP_JAL)) begin
          enc_word = {in_opcode, in_jaddr};
        end else begin
          enc_illegal = 1'b1;
          enc_code    = ERR_JOPC;
        end
      end
      default: begin
        enc_illegal = 1'b1;
        enc_code    = ERR_FMT;
      end
    endcase
  end

  // FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (out_fire && out_last_q) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    done      = (state_q == S_DONE);
    in_ready  = in_ready_q;
    out_valid = out_vld_q;
    out_instr = out_instr_q;
    out_addr  = out_addr_q;
    out_last  = out_last_q;
    err       = err_q;
    err_code  = err_code_q;
  end

  // Elastic buffer, address counter and error tracking.
  always_comb begin
    out_vld_d    = out_vld_q;
    out_instr_d  = out_instr_q;
    out_addr_d   = out_addr_q;
    out_last_d   = out_last_q;
    skid_vld_d   = skid_vld_q;
    skid_instr_d = skid_instr_q;
    skid_addr_d  = skid_addr_q;
    skid_last_d  = skid_last_q;
    addr_d       = addr_q;
    last_acc_d   = last_acc_q;
    err_d        = err_q;
    err_code_d   = err_code_q;

    // Drain first so a same-cycle accept can refill the output register.
    if (out_fire) begin
      if (skid_vld_q) begin
        out_instr_d = skid_instr_q;
        out_addr_d  = skid_addr_q;
        out_last_d  = skid_last_q;
        skid_vld_d  = 1'b0;
      end else begin
        out_vld_d = 1'b0;
      end
    end

    // in_ready_q implies the skid is empty, so an accept always has a slot.
    if (accept) begin
      if (!out_vld_d) begin
        out_vld_d   = 1'b1;
        out_instr_d = enc_word;
        out_addr_d  = addr_q;
        out_last_d  = in_last;
      end else begin
        skid_vld_d   = 1'b1;
        skid_instr_d = enc_word;
        skid_addr_d  = addr_q;
        skid_last_d  = in_last;
      end
      addr_d = addr_q + ADDR_WIDTH'(1);
      if (in_last) last_acc_d = 1'b1;
      if (enc_illegal) begin
        err_d = 1'b1;
        if (!err_q) err_code_d = enc_code;
      end
    end

    if (start_ok) begin
      addr_d     = ADDR_WIDTH'(BASE_ADDR);
      last_acc_d = 1'b0;
      err_d      = 1'b0;
      err_code_d = 2'd0;
    end

    // Registered ready: open only while the skid entry will be free next cycle.
    in_ready_d = (state_d == S_RUN) && !skid_vld_d && !last_acc_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q    <= 1'b0;
      out_instr_q  <= 32'h0000_0000;
      out_addr_q   <= '0;
      out_last_q   <= 1'b0;
      skid_vld_q   <= 1'b0;
      skid_instr_q <= 32'h0000_0000;
      skid_addr_q  <= '0;
      skid_last_q  <= 1'b0;
      addr_q       <= '0;
      last_acc_q   <= 1'b0;
      in_ready_q   <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= 2'd0;
    end else begin
      out_vld_q    <= out_vld_d;
      out_instr_q  <= out_instr_d;
      out_addr_q   <= out_addr_d;
      out_last_q   <= out_last_d;
      skid_vld_q   <= skid_vld_d;
      skid_instr_q <= skid_instr_d;
      skid_addr_q  <= skid_addr_d;
      skid_last_q  <= skid_last_d;
      addr_q       <= addr_d;
      last_acc_q   <= last_acc_d;
      in_ready_q   <= in_ready_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
    end
  end

endmodule
